// File: rtl/ula_right_shift_seq.sv
// Sequential right shifter: shifts a_in right by min(b_in, BITS) places, one bit per clock,
// with a start/busy/done handshake. Define ULA_SHIFT_ARITH_EN to honour arith_in (sign fill).
`ifndef BITS
`define BITS 8
`endif

module ula_right_shift_seq #(
    parameter int unsigned BITS  = `BITS,
    parameter int unsigned CNT_W = $clog2(BITS) + 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic            arith_in,
    output logic [BITS-1:0] result_out,
    output logic            busy_out,
    output logic            done_out
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam int unsigned CmpW = (BITS > 32) ? BITS : 32;

    state_e           state_q, state_d;
    logic [BITS-1:0]  sh_q, sh_d;
    logic [BITS-1:0]  res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CmpW-1:0]  b_ext;
    logic [CNT_W-1:0] cnt_load;
    logic             fill_sel;

    // Amounts of BITS or more all give the same result, so saturate the counter.
    assign b_ext    = CmpW'(b_in);
    assign cnt_load = (b_ext >= CmpW'(BITS)) ? CNT_W'(BITS) : CNT_W'(b_in);

`ifdef ULA_SHIFT_ARITH_EN
    assign fill_sel = arith_in & a_in[BITS-1];
`else
    logic unused_arith;
    assign unused_arith = arith_in;
    assign fill_sel     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    sh_d    = a_in;
                    fill_d  = fill_sel;
                    cnt_d   = cnt_load;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    res_d   = sh_q;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    sh_d   = {fill_q, sh_q[BITS-1:1]};
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                // A start seen here is deliberately not accepted.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result_out = res_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;

endmodule
